// File: rtl/if_stage_mo.sv
// Instruction-fetch stage with multiple outstanding SRAM requests and an instruction buffer.
// Optional macro IF_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module if_stage_mo #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4,
    parameter int          FS_TO_DS_BUS_WD = 65
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       fs_flush,
    input  logic [31:0]                flush_pc,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = $clog2(IBUF_DEPTH + 1);

    logic [31:0]                pf_pc_q, pf_pc_d;
    logic [OW-1:0]              outst_q, outst_d;
    logic [OW-1:0]              discard_q, discard_d;
    logic                       halt_q, halt_d;
    logic [PW-1:0]              pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
    logic [31:0]                pq_mem_q [MAX_OUTSTANDING];
    logic [IW-1:0]              ib_rd_q, ib_rd_d, ib_wr_q, ib_wr_d;
    logic [CW-1:0]              ib_cnt_q, ib_cnt_d;
    logic [FS_TO_DS_BUS_WD-1:0] ib_mem_q [IBUF_DEPTH];

    logic                       redirect;
    logic [31:0]                redirect_pc;
    logic                       pc_misaligned;
    logic [31:0]                live_entries;
    logic                       hs;
    logic                       resp;
    logic                       resp_keep;
    logic [FS_TO_DS_BUS_WD-1:0] resp_entry;
    logic                       ib_empty;
    logic                       ib_pop;
    logic                       ib_push;
    logic [FS_TO_DS_BUS_WD-1:0] ib_wdata;
    logic                       adef_push;
    logic                       bypass_hit;
    logic                       bypass_taken;

    function automatic logic [PW-1:0] pq_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'h2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = pf_pc_q;

    always_comb begin
        redirect      = fs_flush | br_taken;
        redirect_pc   = fs_flush ? flush_pc : br_target;
        pc_misaligned = (pf_pc_q[1:0] != 2'b00);
        // Buffered entries plus responses still owed to the buffer (stale ones excluded).
        live_entries  = 32'(ib_cnt_q) + 32'(outst_q) - 32'(discard_q);

        inst_sram_req = !reset && !redirect && !halt_q && !pc_misaligned
                        && (outst_q < OW'(MAX_OUTSTANDING))
                        && (live_entries < 32'(IBUF_DEPTH));
        hs            = inst_sram_req && inst_sram_addr_ok;

        resp       = inst_sram_data_ok && (outst_q != '0);
        resp_keep  = resp && (discard_q == '0) && !redirect;
        resp_entry = FS_TO_DS_BUS_WD'({1'b0, inst_sram_rdata, pq_mem_q[pq_rd_q]});
        ib_empty   = (ib_cnt_q == '0);

`ifdef IF_BYPASS_EN
        bypass_hit   = resp_keep && ib_empty;
        fs_to_ds_bus = ib_empty ? resp_entry : ib_mem_q[ib_rd_q];
`else
        bypass_hit   = 1'b0;
        fs_to_ds_bus = ib_mem_q[ib_rd_q];
`endif
        bypass_taken   = bypass_hit && ds_allowin;
        fs_to_ds_valid = !reset && !redirect && (!ib_empty || bypass_hit);
        ib_pop         = !ib_empty && !redirect && ds_allowin;

        adef_push = !redirect && !halt_q && pc_misaligned && !resp_keep
                    && ((ib_cnt_q != CW'(IBUF_DEPTH)) || ib_pop);
        ib_push   = !reset && ((resp_keep && !bypass_taken) || adef_push);
        ib_wdata  = adef_push ? FS_TO_DS_BUS_WD'({1'b1, 32'h0, pf_pc_q}) : resp_entry;
    end

    always_comb begin
        pf_pc_d   = pf_pc_q;
        outst_d   = outst_q + OW'(hs) - OW'(resp);
        discard_d = discard_q;
        halt_d    = halt_q;
        pq_wr_d   = hs ? pq_inc(pq_wr_q) : pq_wr_q;
        pq_rd_d   = resp ? pq_inc(pq_rd_q) : pq_rd_q;
        ib_wr_d   = ib_wr_q + IW'(ib_push);
        ib_rd_d   = ib_rd_q + IW'(ib_pop);
        ib_cnt_d  = ib_cnt_q + CW'(ib_push) - CW'(ib_pop);

        if (hs) begin
            pf_pc_d = pf_pc_q + 32'd4;
        end
        if (resp && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (adef_push) begin
            halt_d = 1'b1;
        end
        // Everything still in flight after this cycle belongs to the old path; the
        // pending-PC queue keeps draining as those responses return.
        if (redirect) begin
            pf_pc_d   = redirect_pc;
            discard_d = outst_d;
            halt_d    = 1'b0;
            ib_rd_d   = ib_wr_q;
            ib_wr_d   = ib_wr_q;
            ib_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_pc_q   <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            halt_q    <= 1'b0;
            pq_rd_q   <= '0;
            pq_wr_q   <= '0;
            ib_rd_q   <= '0;
            ib_wr_q   <= '0;
            ib_cnt_q  <= '0;
        end else begin
            pf_pc_q   <= pf_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            halt_q    <= halt_d;
            pq_rd_q   <= pq_rd_d;
            pq_wr_q   <= pq_wr_d;
            ib_rd_q   <= ib_rd_d;
            ib_wr_q   <= ib_wr_d;
            ib_cnt_q  <= ib_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            pq_mem_q[pq_wr_q] <= pf_pc_q;
        end
        if (ib_push) begin
            ib_mem_q[ib_wr_q] <= ib_wdata;
        end
    end

endmodule

// File: tb/tb_if_stage_mo.sv
// Randomised bench for if_stage_mo: an in-order SRAM model plus a queue-level model of
// what decode must see and when the stage may issue a request.
module tb_if_stage_mo;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int MAXO  = 2;
    localparam int DEPTH = 4;
    localparam int BW    = 65;

    logic          clk = 1'b0;
    logic          reset;
    logic          ds_allowin;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          fs_flush;
    logic [31:0]   flush_pc;
    logic          fs_to_ds_valid;
    logic [BW-1:0] fs_to_ds_bus;
    logic          inst_sram_req;
    logic          inst_sram_wr;
    logic [1:0]    inst_sram_size;
    logic [3:0]    inst_sram_wstrb;
    logic [31:0]   inst_sram_addr;
    logic [31:0]   inst_sram_wdata;
    logic          inst_sram_addr_ok;
    logic          inst_sram_data_ok;
    logic [31:0]   inst_sram_rdata;

    always #5 clk = ~clk;

    if_stage_mo #(
        .RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH), .FS_TO_DS_BUS_WD(BW)
    ) dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
        .br_taken(br_taken), .br_target(br_target),
        .fs_flush(fs_flush), .flush_pc(flush_pc),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } mreq_t;

    int            checks = 0;
    int            errors = 0;
    mreq_t         mem_q[$];
    logic [BW-1:0] ibq[$];
    logic [31:0]   next_pc;
    bit            halt_m;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hbeef, ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        ibq.delete();
        next_pc = RESET_PC;
        halt_m  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            br_taken = 1'b0; fs_flush = 1'b0; ds_allowin = 1'b0;
            inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
            #1;
            chk("reset_req", inst_sram_req, 1'b0);
            chk("reset_valid", fs_to_ds_valid, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, compare the DUT against the model, then advance the model
    // to the state it should hold after the coming edge.
    task automatic cycle(input bit br, input logic [31:0] bt, input bit fl, input logic [31:0] ft,
                         input int pa, input int pd, input int pw, input bit force_dok);
        bit            redir, dok, keep, byp, exp_req, exp_valid, deliver, had_room;
        logic [31:0]   tgt;
        logic [BW-1:0] rent;
        int            live;
        mreq_t         r, m;

        @(negedge clk);
        br_taken  = br; br_target = bt;
        fs_flush  = fl; flush_pc  = ft;
        inst_sram_addr_ok = ($urandom_range(99, 0) < pa);
        ds_allowin        = ($urandom_range(99, 0) < pw);
        dok = (mem_q.size() > 0) && (force_dok || ($urandom_range(99, 0) < pd));
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? inst_of(mem_q[0].addr) : $urandom;
        #1;

        redir = br | fl;
        tgt   = fl ? ft : bt;
        live  = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) live++;

        exp_req = !redir && !halt_m && (next_pc[1:0] == 2'b00)
                  && (mem_q.size() < MAXO) && (ibq.size() + live < DEPTH);
        chk("req", inst_sram_req, exp_req);
        if (exp_req) chk("addr", inst_sram_addr, next_pc);

        keep = 1'b0;
        rent = '0;
        if (dok) begin
            r    = mem_q[0];
            keep = !r.stale && !redir;
            rent = {1'b0, inst_of(r.addr), r.addr};
        end
        byp = 1'b0;
`ifdef IF_BYPASS_EN
        byp = keep && (ibq.size() == 0);
`endif
        exp_valid = !redir && ((ibq.size() > 0) || byp);
        chk("valid", fs_to_ds_valid, exp_valid);
        if (exp_valid) chk("bus", fs_to_ds_bus, (ibq.size() > 0) ? ibq[0] : rent);

        deliver  = exp_valid && ds_allowin;
        had_room = (ibq.size() < DEPTH) || (deliver && ibq.size() > 0);
        if (deliver && ibq.size() > 0) void'(ibq.pop_front());
        if (dok) begin
            void'(mem_q.pop_front());
            if (keep && !(byp && deliver)) ibq.push_back(rent);
        end
        if (!redir && !halt_m && (next_pc[1:0] != 2'b00) && had_room) begin
            ibq.push_back({1'b1, 32'h0, next_pc});
            halt_m = 1'b1;
        end
        if (redir) begin
            ibq.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            next_pc = tgt;
            halt_m  = 1'b0;
        end
        if (exp_req && inst_sram_addr_ok) begin
            m.addr = next_pc; m.stale = 1'b0;
            mem_q.push_back(m);
            next_pc = next_pc + 32'd4;
        end
        @(posedge clk);
    endtask

    task automatic run(input int n, input int pa, input int pd, input int pw);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, pa, pd, pw, 1'b0);
    endtask

    logic [31:0] rt;

    initial begin
        reset = 1'b1; ds_allowin = 1'b0; br_taken = 1'b0; br_target = '0;
        fs_flush = 1'b0; flush_pc = '0; inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
        model_reset();
        do_reset(3);

        // free-running fetch from RESET_PC
        run(30, 100, 100, 100);
        // decode stalled, then released
        run(10, 100, 100, 0);
        run(20, 100, 100, 100);

        // branch while two requests are in flight
        run(3, 100, 0, 100);
        cycle(1'b1, 32'h1c000100, 1'b0, 32'h0, 100, 0, 100, 1'b0);
        run(20, 100, 100, 100);

        // flush and branch together: flush wins
        run(2, 100, 0, 100);
        cycle(1'b1, 32'h1c000100, 1'b1, 32'h1c000800, 100, 0, 100, 1'b0);
        run(15, 100, 100, 100);

        // misaligned target raises ADEF and halts fetch until a flush
        cycle(1'b1, 32'h1c000102, 1'b0, 32'h0, 100, 50, 100, 1'b0);
        run(12, 100, 100, 100);
        cycle(1'b0, 32'h0, 1'b1, 32'h1c000800, 100, 100, 100, 1'b0);
        run(15, 100, 100, 100);

        // redirect in the same cycle as a response
        run(3, 100, 0, 100);
        cycle(1'b1, 32'h1c000200, 1'b0, 32'h0, 100, 0, 100, 1'b1);
        run(15, 100, 100, 100);

        // randomised traffic with occasional redirects
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99, 0) < 3) begin
                rt = RESET_PC + {22'h0, 8'($urandom_range(255, 0)), 2'b00};
                if ($urandom_range(7, 0) == 0) rt[1:0] = 2'($urandom_range(3, 1));
                cycle(1'b1, rt, ($urandom_range(1, 0) == 1), rt + 32'h400,
                      $urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 20),
                      ($urandom_range(1, 0) == 1));
            end else begin
                cycle(1'b0, 32'h0, 1'b0, 32'h0,
                      $urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 20), 1'b0);
            end
            if (i == 1000) do_reset(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
